// File: rtl/pipeline_elastic_stage.sv
// Elastic pipeline register: circular buffer of DEPTH slots with valid/ready on both sides.
// Optional PIPELINE_ELASTIC_STAGE_PERF_EN adds saturating stall/bubble cycle counters.
module pipeline_elastic_stage #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DEPTH           = 2,
    parameter bit          ZERO_WHEN_EMPTY = 1'b1,
    parameter int unsigned CNT_WIDTH       = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  count
`ifdef PIPELINE_ELASTIC_STAGE_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           bubble_cycles
`endif
);

    localparam int unsigned          PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] DepthC  = CNT_WIDTH'(DEPTH);
    localparam logic [PtrW-1:0]      LastPtr = PtrW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  occ_q, occ_d;
    logic                  enq, deq;

    // Readiness uses registered occupancy only, so a full buffer never accepts even while draining.
    assign in_ready  = !stall && (occ_q < DepthC);
    assign out_valid = !stall && (occ_q != '0);
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;
    assign count     = occ_q;

    always_comb begin
        out_data = mem_q[rd_ptr_q];
        if (ZERO_WHEN_EMPTY && !out_valid) begin
            out_data = '0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (deq) begin
                rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            unique case ({enq, deq})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Payload slots are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (enq && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef PIPELINE_ELASTIC_STAGE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (in_valid && !in_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (out_ready && !out_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles  = stall_cnt_q;
    assign bubble_cycles = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_elastic_stage.sv
// Scoreboard bench for pipeline_elastic_stage: a DEPTH=2 and a DEPTH=4 instance.
// Perf-counter checks are compiled in when PIPELINE_ELASTIC_STAGE_PERF_EN is defined.
module tb_pipeline_elastic_stage;

    logic        clk;
    logic        rst;
    int          errors;
    int          checks;

    logic        flush2, stall2, in_valid2, in_ready2, out_valid2, out_ready2;
    logic [31:0] in_data2, out_data2;
    logic [1:0]  count2;

    logic        flush4, stall4, in_valid4, in_ready4, out_valid4, out_ready4;
    logic [31:0] in_data4, out_data4;
    logic [2:0]  count4;

`ifdef PIPELINE_ELASTIC_STAGE_PERF_EN
    logic [31:0] stall_cycles2, bubble_cycles2, stall_cycles4, bubble_cycles4;
`endif

    logic [31:0] exp2[$];
    logic [31:0] exp4[$];

    pipeline_elastic_stage #(.DATA_WIDTH(32), .DEPTH(2), .ZERO_WHEN_EMPTY(1'b1)) u_d2 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush2),
        .stall     (stall2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_data   (in_data2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_data  (out_data2),
        .count     (count2)
`ifdef PIPELINE_ELASTIC_STAGE_PERF_EN
        ,
        .stall_cycles  (stall_cycles2),
        .bubble_cycles (bubble_cycles2)
`endif
    );

    pipeline_elastic_stage #(.DATA_WIDTH(32), .DEPTH(4), .ZERO_WHEN_EMPTY(1'b1)) u_d4 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush4),
        .stall     (stall4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4),
        .count     (count4)
`ifdef PIPELINE_ELASTIC_STAGE_PERF_EN
        ,
        .stall_cycles  (stall_cycles4),
        .bubble_cycles (bubble_cycles4)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain2();
        int n = 0;
        while (exp2.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        chk("d2_drain_left", 32'(exp2.size()), 32'd0);
    endtask

    task automatic drain4();
        int n = 0;
        while (exp4.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        chk("d4_drain_left", 32'(exp4.size()), 32'd0);
        @(negedge clk);
        chk("d4_drain_count", 32'(count4), 32'd0);
        tick();
    endtask

    // Output monitors: every downstream handshake must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && !flush2 && out_valid2 && out_ready2) begin
            if (exp2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d2_unexpected_out: got %h expected none", out_data2);
            end else begin
                chk("d2_out_data", out_data2, exp2.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && !flush4 && out_valid4 && out_ready4) begin
            if (exp4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d4_unexpected_out: got %h expected none", out_data4);
            end else begin
                chk("d4_out_data", out_data4, exp4.pop_front());
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        flush2 = 1'b0; stall2 = 1'b0; in_valid2 = 1'b1; in_data2 = 32'hDEAD_BEEF; out_ready2 = 1'b0;
        flush4 = 1'b0; stall4 = 1'b0; in_valid4 = 1'b1; in_data4 = 32'hDEAD_BEEF; out_ready4 = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count2", 32'(count2), 32'd0);
        chk("rst_out_valid2", 32'(out_valid2), 32'd0);
        chk("rst_out_data2", out_data2, 32'd0);
        chk("rst_count4", 32'(count4), 32'd0);
        tick();
        rst = 1'b0;
        in_valid2 = 1'b0;
        in_valid4 = 1'b0;
        @(negedge clk);
        chk("rel_in_ready2", 32'(in_ready2), 32'd1);
        chk("rel_count2", 32'(count2), 32'd0);
        tick();

        // Streaming on DEPTH=2
        out_ready2 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid2 = 1'b1;
            in_data2  = 32'(i);
            exp2.push_back(32'(i));
            @(negedge clk);
            chk("stream_in_ready", 32'(in_ready2), 32'd1);
            if (i > 1) chk("stream_count", 32'(count2), 32'd1);
            tick();
        end
        in_valid2 = 1'b0;
        @(negedge clk);
        chk("stream_last_count", 32'(count2), 32'd1);
        chk("stream_last_valid", 32'(out_valid2), 32'd1);
        tick();
        drain2();
        out_ready2 = 1'b0;

        // Fill / backpressure on DEPTH=4
        for (int i = 0; i < 6; i++) exp4.push_back(32'hA0 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            in_valid4 = 1'b1;
            in_data4  = 32'hA0 + 32'(i);
            @(negedge clk);
            chk("fill_in_ready", 32'(in_ready4), 32'd1);
            tick();
        end
        in_data4 = 32'hA4;
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready4), 32'd0);
        chk("full_count", 32'(count4), 32'd4);
        tick();
        @(negedge clk);
        chk("full_hold_in_ready", 32'(in_ready4), 32'd0);
        tick();
        out_ready4 = 1'b1;
        @(negedge clk);
        chk("full_deq_in_ready", 32'(in_ready4), 32'd0);
        tick();
        @(negedge clk);
        chk("after_deq_in_ready", 32'(in_ready4), 32'd1);
        chk("after_deq_count", 32'(count4), 32'd3);
        tick();
        in_data4 = 32'hA5;
        @(negedge clk);
        chk("a5_count", 32'(count4), 32'd3);
        tick();
        in_valid4 = 1'b0;
        drain4();
        out_ready4 = 1'b0;

        // Stall with occ=2
        exp4.push_back(32'hB0);
        exp4.push_back(32'hB1);
        exp4.push_back(32'hB2);
        in_valid4 = 1'b1;
        in_data4  = 32'hB0;
        tick();
        in_data4  = 32'hB1;
        tick();
        stall4     = 1'b1;
        in_data4   = 32'hB2;
        out_ready4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready4), 32'd0);
            chk("stall_out_valid", 32'(out_valid4), 32'd0);
            chk("stall_count", 32'(count4), 32'd2);
            chk("stall_out_data", out_data4, 32'd0);
            tick();
        end
        stall4 = 1'b0;
        @(negedge clk);
        chk("unstall_count", 32'(count4), 32'd2);
        chk("unstall_in_ready", 32'(in_ready4), 32'd1);
        tick();
        in_valid4 = 1'b0;
        drain4();
        out_ready4 = 1'b0;

        // Flush with enq and deq on the flush cycle
        exp4.push_back(32'hC0);
        exp4.push_back(32'hC1);
        exp4.push_back(32'hC2);
        in_valid4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data4 = 32'hC0 + 32'(i);
            tick();
        end
        @(negedge clk);
        chk("preflush_count", 32'(count4), 32'd3);
        tick();
        flush4     = 1'b1;
        in_data4   = 32'hCC;
        out_ready4 = 1'b1;
        exp4.delete();
        tick();
        flush4    = 1'b0;
        in_valid4 = 1'b0;
        @(negedge clk);
        chk("flush_count", 32'(count4), 32'd0);
        chk("flush_out_valid", 32'(out_valid4), 32'd0);
        chk("flush_out_data", out_data4, 32'd0);
        tick();
        in_valid4 = 1'b1;
        in_data4  = 32'h55;
        exp4.push_back(32'h55);
        tick();
        in_valid4 = 1'b0;
        drain4();
        out_ready4 = 1'b0;

`ifdef PIPELINE_ELASTIC_STAGE_PERF_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid4 = 1'b1;
        in_data4  = 32'h77;
        repeat (4) tick();
        repeat (5) tick();
        in_valid4 = 1'b0;
        @(negedge clk);
        chk("perf_stall", stall_cycles4, 32'd5);
        chk("perf_bubble0", bubble_cycles4, 32'd0);
        tick();
        flush4 = 1'b1;
        tick();
        flush4 = 1'b0;
        out_ready4 = 1'b1;
        repeat (3) tick();
        out_ready4 = 1'b0;
        @(negedge clk);
        chk("perf_stall_after_flush", stall_cycles4, 32'd5);
        chk("perf_bubble", bubble_cycles4, 32'd3);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("perf_rst_stall", stall_cycles4, 32'd0);
        chk("perf_rst_bubble", bubble_cycles4, 32'd0);
        tick();
        rst = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
